// File: rtl/digit_scrambler_pkg.sv
// Shared definitions for the tube digit scrambler: state encoding, default
// geometry and the blank segment pattern.
package digit_scrambler_pkg;

  localparam int SEG_W_DEF    = 7;
  localparam int N_DIGITS_DEF = 8;

  localparam logic [SEG_W_DEF-1:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCRAMBLE = 2'd1,
    ST_LOCK     = 2'd2
  } state_t;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/digit_scrambler_if.sv
// Segment/strobe bundle between the formatter/noise side and the scrambler.
// Digit k sits at [k], i.e. flat bits [SEG_W*k+SEG_W-1:SEG_W*k].
interface digit_scrambler_if
  import digit_scrambler_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF,
  parameter int SEG_W    = SEG_W_DEF
);
  logic                               tick;
  logic                               start;
  logic [N_DIGITS-1:0][SEG_W-1:0]     seg_in;
  logic [N_DIGITS-1:0][SEG_W-1:0]     noise_in;
  logic [N_DIGITS-1:0][SEG_W-1:0]     seg_out;
  logic                               busy;

  modport master (output tick, start, seg_in, noise_in, input seg_out, busy);
  modport slave  (input tick, start, seg_in, noise_in, output seg_out, busy);
endinterface

// File: rtl/digit_scrambler_mux.sv
// Per-tube next-value select: real digit when idle or locked, noise otherwise.
module scramble_digit_mux #(
  parameter int SEG_W = 7
) (
  input  logic [SEG_W-1:0] real_seg,
  input  logic [SEG_W-1:0] noise_seg,
  input  logic             locked,
  input  logic             scrambling,
  output logic [SEG_W-1:0] next_seg
);
  assign next_seg = (!scrambling || locked) ? real_seg : noise_seg;
endmodule

// File: rtl/digit_scrambler.sv
// Slot-machine effect for the tube display: full noise for SCRAMBLE_TICKS,
// then tubes lock left to right every LOCK_TICKS; transparent (1 reg) when idle.
module digit_scrambler
  import digit_scrambler_pkg::*;
#(
  parameter int N_DIGITS       = N_DIGITS_DEF,
  parameter int SEG_W          = SEG_W_DEF,
  parameter int SCRAMBLE_TICKS = 16,
  parameter int LOCK_TICKS     = 4
) (
  input  logic             clk,
  input  logic             rstn,
  digit_scrambler_if.slave bus
);

  localparam int TICK_W = $clog2(max_i(SCRAMBLE_TICKS, LOCK_TICKS) + 1);
  localparam int IDX_W  = $clog2(N_DIGITS + 1);

  state_t                         state, state_nxt;
  logic [TICK_W-1:0]              tick_cnt, tick_cnt_nxt;
  logic [IDX_W-1:0]               lock_idx, lock_idx_nxt;
  logic [N_DIGITS-1:0]            lock_mask, lock_mask_nxt;
  logic                           busy_q, busy_nxt;
  logic [N_DIGITS-1:0][SEG_W-1:0] seg_q, seg_nxt;
  logic                           scrambling;

  assign scrambling  = (state != ST_IDLE);
  assign bus.seg_out = seg_q;
  assign bus.busy    = busy_q;

  // Output select uses the pre-edge lock_mask, so a digit shows its real
  // value starting the cycle after the tick that locks it.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    scramble_digit_mux #(.SEG_W(SEG_W)) u_mux (
      .real_seg   (bus.seg_in[g]),
      .noise_seg  (bus.noise_in[g]),
      .locked     (lock_mask[g]),
      .scrambling (scrambling),
      .next_seg   (seg_nxt[g])
    );
  end

  always_comb begin
    state_nxt     = state;
    tick_cnt_nxt  = tick_cnt;
    lock_idx_nxt  = lock_idx;
    lock_mask_nxt = lock_mask;
    busy_nxt      = busy_q;
    case (state)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (bus.start) begin
          state_nxt     = ST_SCRAMBLE;
          tick_cnt_nxt  = '0;
          lock_idx_nxt  = '0;
          lock_mask_nxt = '0;
          busy_nxt      = 1'b1;
        end
      end
      ST_SCRAMBLE: begin
        if (bus.tick) begin
          if (tick_cnt == TICK_W'(SCRAMBLE_TICKS - 1)) begin
            state_nxt    = ST_LOCK;
            tick_cnt_nxt = '0;
          end else begin
            tick_cnt_nxt = tick_cnt + TICK_W'(1);
          end
        end
      end
      ST_LOCK: begin
        if (bus.tick) begin
          if (tick_cnt == TICK_W'(LOCK_TICKS - 1)) begin
            tick_cnt_nxt = '0;
            lock_idx_nxt = lock_idx + IDX_W'(1);
            for (int k = 0; k < N_DIGITS; k++)
              if (lock_idx == IDX_W'(k)) lock_mask_nxt[k] = 1'b1;
            if (lock_idx == IDX_W'(N_DIGITS - 1)) begin
              state_nxt = ST_IDLE;
              busy_nxt  = 1'b0;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + TICK_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      lock_idx  <= '0;
      lock_mask <= '0;
      busy_q    <= 1'b0;
      seg_q     <= {N_DIGITS{SEG_BLANK}};
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_cnt_nxt;
      lock_idx  <= lock_idx_nxt;
      lock_mask <= lock_mask_nxt;
      busy_q    <= busy_nxt;
      seg_q     <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_digit_scrambler.sv
// Directed bench for digit_scrambler: a tick-count model checked every cycle
// plus hand-computed literal expectations at the key points of each sequence.
module tb_digit_scrambler;

  localparam int ND    = 8;
  localparam int SW    = 7;
  localparam int ST    = 16;
  localparam int LT    = 4;
  localparam int TOTAL = ST + ND * LT;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  digit_scrambler_if #(.N_DIGITS(ND), .SEG_W(SW)) dif ();

  digit_scrambler #(
    .N_DIGITS(ND), .SEG_W(SW), .SCRAMBLE_TICKS(ST), .LOCK_TICKS(LT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (dif)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model: a sequence is "ticks seen since start"; digits locked = (n-ST)/LT.
  logic                     m_active = 1'b0;
  int                       m_n = 0;
  logic [ND-1:0][SW-1:0]    exp_seg;
  logic                     exp_busy;
  logic                     model_ok = 1'b0;

  function automatic logic [ND-1:0][SW-1:0] model_seg(
    input int n, input logic [ND-1:0][SW-1:0] r, input logic [ND-1:0][SW-1:0] z);
    logic [ND-1:0][SW-1:0] o;
    int nl;
    nl = (n < ST) ? 0 : (n - ST) / LT;
    for (int k = 0; k < ND; k++) o[k] = (k < nl) ? r[k] : z[k];
    return o;
  endfunction

  always @(posedge clk) begin
    model_ok <= 1'b1;
    if (!rstn) begin
      m_active <= 1'b0;
      m_n      <= 0;
      exp_seg  <= '0;
      exp_busy <= 1'b0;
    end else if (!m_active) begin
      exp_seg  <= dif.seg_in;
      m_active <= dif.start;
      m_n      <= 0;
      exp_busy <= dif.start;
    end else begin
      exp_seg  <= model_seg(m_n, dif.seg_in, dif.noise_in);
      exp_busy <= 1'b1;
      if (dif.tick) begin
        m_n <= m_n + 1;
        if (m_n + 1 == TOTAL) begin
          m_active <= 1'b0;
          exp_busy <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_seg_out", dif.seg_out, exp_seg);
      check("model_busy", dif.busy, exp_busy);
    end
  end

  logic        rnd_noise = 1'b1;
  logic [55:0] noise_const = '0;

  task automatic step(input logic t, input logic s);
    logic [63:0] r64;
    r64 = {$urandom(), $urandom()};
    dif.tick     = t;
    dif.start    = s;
    dif.noise_in = rnd_noise ? r64[55:0] : noise_const;
    @(posedge clk);
    #2;
    dif.tick  = 1'b0;
    dif.start = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0);
      repeat (9) step(1'b0, 1'b0);
    end
  endtask

  initial begin
    dif.tick = 1'b0; dif.start = 1'b0; dif.seg_in = '0; dif.noise_in = '0;
    rstn = 1'b0;
    repeat (2) step(1'b0, 1'b0);
    check("reset_seg_out", dif.seg_out, 56'h0);
    check("reset_busy", dif.busy, 1'b0);

    rstn = 1'b1;
    dif.seg_in = 56'h0123456789ABCD;
    step(1'b0, 1'b0);
    check("idle_pass", dif.seg_out, 56'h0123456789ABCD);
    check("idle_busy", dif.busy, 1'b0);

    // Full sequence with all-ones noise so mixes are hand-computable
    rnd_noise = 1'b0;
    noise_const = 56'hFFFFFFFFFFFFFF;
    step(1'b0, 1'b1);
    check("busy_rise", dif.busy, 1'b1);
    do_ticks(16);
    check("after16_d0_noise", dif.seg_out[0], 7'h7F);
    do_ticks(4);
    check("after20_d0_locked", dif.seg_out, 56'hFFFFFFFFFFFFCD);
    dif.seg_in[0] = 7'h3F;
    step(1'b0, 1'b0);
    check("live_d0_3f", dif.seg_out[0], 7'h3F);
    dif.seg_in[0] = 7'h06;
    step(1'b0, 1'b0);
    check("live_d0_06", dif.seg_out, 56'hFFFFFFFFFFFF86);
    do_ticks(10);
    step(1'b0, 1'b1);
    do_ticks(17);
    check("after47_busy", dif.busy, 1'b1);
    check("after47_d7_noise", dif.seg_out[7], 7'h7F);
    do_ticks(1);
    check("after48_busy", dif.busy, 1'b0);
    check("after48_seg", dif.seg_out, 56'h0123456789AB86);

    // start and tick together: that tick must not count
    noise_const = 56'h0;
    step(1'b1, 1'b1);
    do_ticks(19);
    check("simul_19_d0_noise", dif.seg_out[0], 7'h00);
    do_ticks(1);
    check("simul_20_d0_locked", dif.seg_out[0], 7'h06);

    rnd_noise = 1'b1;
    do_ticks(5);
    rstn = 1'b0;
    step(1'b0, 1'b0);
    check("midrst_seg", dif.seg_out, 56'h0);
    check("midrst_busy", dif.busy, 1'b0);
    rstn = 1'b1;
    step(1'b0, 1'b0);
    check("postrst_seg", dif.seg_out, 56'h0123456789AB86);

    dif.seg_in = 56'h13579BDF02468A;
    step(1'b0, 1'b1);
    do_ticks(47);
    check("rerun47_busy", dif.busy, 1'b1);
    do_ticks(1);
    check("rerun48_busy", dif.busy, 1'b0);
    check("rerun48_seg", dif.seg_out, 56'h13579BDF02468A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
